// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix-keypad scanner.
//   state_e        : debounce/hold FSM states
//   PHONE_MAP_TBL  : 4x4 telephone-layout code table, indexed by raw code r*4+c
//   map_key()      : raw code -> delivered key code
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  // Entry i is the key code for raw index i (entry 0 is the rightmost element).
  localparam logic [15:0][3:0] PHONE_MAP_TBL = {
    4'd13, 4'd14, 4'd0,  4'd15,   // row 3
    4'd12, 4'd9,  4'd8,  4'd7,    // row 2
    4'd11, 4'd6,  4'd5,  4'd4,    // row 1
    4'd10, 4'd3,  4'd2,  4'd1     // row 0
  };

  // Telephone layout only applies when enabled and the raw index fits the table.
  function automatic int unsigned map_key(input int unsigned raw, input bit phone_en);
    if (phone_en && (raw < 32'd16)) begin
      return 32'(PHONE_MAP_TBL[raw[3:0]]);
    end
    return raw;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk_i : sampling clock
//   rst_i : synchronous active-high reset, clears both stages
//   d_i   : asynchronous input bus (W bits)
//   q_o   : synchronised bus, 2 cycles behind d_i
module keypad_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Parametrised matrix-keypad scanner.
// Strobes rows one-hot, samples the synchronised columns at the end of each row dwell,
// accumulates per-frame key statistics and runs a debounce/hold/release FSM that emits
// key codes with single-cycle valid pulses and optional typematic repeat.
//   clk       : system clock (rising edge)
//   rst       : synchronous active-high reset
//   col       : raw column returns, asynchronous, active-high
//   row       : one-hot row strobe, active-high (row index r drives row[ROWS-1-r])
//   key       : code of the last accepted key, held until the next acceptance
//   key_valid : one-cycle pulse on acceptance or repeat
//   key_down  : high from acceptance until the release is debounced
//   key_up    : one-cycle pulse when the release is debounced
module keypad_scanner #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 2500000,
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned REPEAT_FRAMES   = 0,
  parameter int unsigned PHONE_MAP       = 1,
  localparam int unsigned KEY_W =
      ($clog2(ROWS * COLS) < 4) ? 4 : $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  col,
  output logic [ROWS-1:0]  row,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_down,
  output logic             key_up
);

  import keypad_pkg::*;

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int unsigned RepW   = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [RowW-1:0]   LastRow   = RowW'(ROWS - 1);
  localparam logic [CntW-1:0]   DebTarget = CntW'(DEBOUNCE_FRAMES);
  localparam logic [RepW-1:0]   RepTarget = RepW'(REPEAT_FRAMES);
  localparam bit                PhoneEn   = (PHONE_MAP != 0) && (ROWS == 4) && (COLS == 4);

  // ---------------------------------------------------------------------------
  // Column synchroniser
  // ---------------------------------------------------------------------------
  logic [COLS-1:0] col_sync;

  keypad_sync #(
    .W (COLS)
  ) u_col_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (col),
    .q_o   (col_sync)
  );

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [RowW-1:0]   row_idx_q, row_idx_d;
  logic              sample;
  logic              frame_end;

  assign sample    = (dwell_q == DwellLast);
  assign frame_end = sample && (row_idx_q == LastRow);

  always_comb begin
    dwell_d   = dwell_q + DwellW'(1);
    row_idx_d = row_idx_q;
    if (sample) begin
      dwell_d   = '0;
      row_idx_d = (row_idx_q == LastRow) ? '0 : row_idx_q + RowW'(1);
    end
  end

  always_comb begin
    row = '0;
    for (int r = 0; r < ROWS; r++) begin
      row[ROWS-1-r] = (row_idx_q == RowW'(r));
    end
  end

  // ---------------------------------------------------------------------------
  // Frame accumulation
  // ---------------------------------------------------------------------------
  logic [1:0]       acc_cnt_q, acc_cnt_d;     // asserted keys, saturating at 2
  logic [KEY_W-1:0] acc_code_q, acc_code_d;   // raw code of the last asserted key
  logic             acc_hit_q, acc_hit_d;     // candidate position seen asserted
  logic [KEY_W-1:0] cand_q, cand_d;

  // Frame totals including the row being sampled this cycle; only used when sample=1.
  logic [1:0]       frame_cnt;
  logic [KEY_W-1:0] frame_code;
  logic             frame_hit;
  logic [KEY_W-1:0] pos_code;

  always_comb begin
    frame_cnt  = acc_cnt_q;
    frame_code = acc_code_q;
    frame_hit  = acc_hit_q;
    pos_code   = '0;
    for (int c = 0; c < COLS; c++) begin
      pos_code = KEY_W'(int'(row_idx_q) * int'(COLS) + c);
      if (col_sync[COLS-1-c]) begin
        if (frame_cnt != 2'd2) begin
          frame_cnt = frame_cnt + 2'd1;
        end
        frame_code = pos_code;
        if (pos_code == cand_q) begin
          frame_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    acc_hit_d  = acc_hit_q;
    if (sample) begin
      if (frame_end) begin
        acc_cnt_d  = '0;
        acc_code_d = '0;
        acc_hit_d  = 1'b0;
      end else begin
        acc_cnt_d  = frame_cnt;
        acc_code_d = frame_code;
        acc_hit_d  = frame_hit;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce / hold / release FSM, evaluated once per frame
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             key_up_q, key_up_d;
  logic             accept;
  logic             release_key;
  logic [KEY_W-1:0] accept_code;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    key_up_d    = 1'b0;
    accept      = 1'b0;
    release_key = 1'b0;
    accept_code = cand_q;

    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_cnt == 2'd1) begin
            cand_d = frame_code;
            if (DEBOUNCE_FRAMES <= 1) begin
              accept      = 1'b1;
              accept_code = frame_code;
            end else begin
              cnt_d   = CntW'(1);
              state_d = StDebounce;
            end
          end
        end

        StDebounce: begin
          if ((frame_cnt == 2'd1) && (frame_code == cand_q)) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d >= DebTarget) begin
              accept = 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end

        StHeld: begin
          if (frame_hit) begin
            // Other keys pressed alongside the held one are ignored here.
            if (REPEAT_FRAMES > 0) begin
              rep_d = rep_q + RepW'(1);
              if (rep_d == RepTarget) begin
                key_valid_d = 1'b1;
                rep_d       = '0;
              end
            end
          end else if (DEBOUNCE_FRAMES <= 1) begin
            release_key = 1'b1;
          end else begin
            cnt_d   = CntW'(1);
            state_d = StRelease;
          end
        end

        StRelease: begin
          if (!frame_hit) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d >= DebTarget) begin
              release_key = 1'b1;
            end
          end else begin
            // Bounce during release: the repeat phase continues where it left off.
            state_d = StHeld;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (accept) begin
      key_d       = KEY_W'(map_key(32'(accept_code), PhoneEn));
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      cnt_d       = '0;
      rep_d       = '0;
      state_d     = StHeld;
    end

    if (release_key) begin
      key_down_d = 1'b0;
      key_up_d   = 1'b1;
      cnt_d      = '0;
      state_d    = StIdle;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q     <= '0;
      row_idx_q   <= '0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      acc_hit_q   <= 1'b0;
      cand_q      <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      rep_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      key_up_q    <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      acc_hit_q   <= acc_hit_d;
      cand_q      <= cand_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      key_up_q    <= key_up_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign key_up    = key_up_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: three instances (4x4 phone map, 4x4 with repeat, 3x5 raw).
// A keypad model turns pressed[r][c] into column returns. Stimulus pushes expected
// key_valid/key_up events (instance, kind, code, cycle) into a queue; a monitor pops
// and compares whenever any instance pulses an output.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int inst;
    bit up;
    int key;
    int at;
  } ev_t;

  ev_t sbq[$];

  logic [3:0] col0, row0, col1, row1;
  logic [4:0] col2;
  logic [2:0] row2;
  logic [3:0] k  [3];
  logic       kv [3];
  logic       kd [3];
  logic       ku [3];

  bit p0 [4][4];
  bit p1 [4][4];
  bit p2 [3][5];

  // Keypad model: a pressed switch connects its row strobe to its column return.
  always_comb begin
    col0 = '0;
    col1 = '0;
    col2 = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row0[3-r] && p0[r][c]) col0[3-c] = 1'b1;
        if (row1[3-r] && p1[r][c]) col1[3-c] = 1'b1;
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (row2[2-r] && p2[r][c]) col2[4-c] = 1'b1;
      end
    end
  end

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(0), .PHONE_MAP(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .col(col0), .row(row0), .key(k[0]),
    .key_valid(kv[0]), .key_down(kd[0]), .key_up(ku[0])
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(3), .PHONE_MAP(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .col(col1), .row(row1), .key(k[1]),
    .key_valid(kv[1]), .key_down(kd[1]), .key_up(ku[1])
  );

  keypad_scanner #(
    .ROWS(3), .COLS(5), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .REPEAT_FRAMES(0), .PHONE_MAP(0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .col(col2), .row(row2), .key(k[2]),
    .key_valid(kv[2]), .key_down(kd[2]), .key_up(ku[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int inst, input bit up, input int key, input int at);
    ev_t e;
    e.inst = inst;
    e.up   = up;
    e.key  = key;
    e.at   = at;
    sbq.push_back(e);
  endtask

  function automatic logic top_bit(input int inst);
    if (inst == 2) return row2[2];
    if (inst == 1) return row1[3];
    return row0[3];
  endfunction

  // Leaves the caller 1 time unit after the edge that starts a new frame (row index 0).
  task automatic align(input int inst);
    logic prev, now;
    bit   found;
    found = 1'b0;
    prev  = top_bit(inst);
    for (int n = 0; n < 64 && !found; n++) begin
      @(posedge clk);
      #1;
      now = top_bit(inst);
      if (now && !prev) found = 1'b1;
      prev = now;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL align inst=%0d: no frame start within 64 cycles", inst);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (kv[i] === 1'b1 || ku[i] === 1'b1) begin
        checks++;
        if (kv[i] === 1'b1 && ku[i] === 1'b1) begin
          errors++;
          $display("FAIL pulse_overlap inst=%0d: valid and up both high at cycle %0d", i, cyc);
        end else if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event inst=%0d: got up=%0b key=%0d at cycle %0d, expected none",
                   i, ku[i], k[i], cyc);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          if (e.inst != i || e.up != ku[i] || e.key != int'(k[i]) || e.at != cyc) begin
            errors++;
            $display("FAIL event inst=%0d: got up=%0b key=%0d cycle=%0d, expected inst=%0d up=%0b key=%0d cycle=%0d",
                     i, ku[i], k[i], cyc, e.inst, e.up, e.key, e.at);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [3:0] rexp;

    // Reset and scan order.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_row0", row0, 4'b1000);
    chk("reset_row2", row2, 3'b100);
    chk("reset_key", k[0], 0);
    chk("reset_valid", kv[0], 0);
    chk("reset_down", kd[0], 0);
    chk("reset_up", ku[0], 0);
    for (int i = 1; i <= 4; i++) begin
      repeat (4) @(posedge clk);
      #1;
      rexp = 4'b1000 >> (i % 4);
      chk("scan_order", row0, rexp);
    end

    // Single press of key 5 (r1,c1) for 3 frames, then release.
    align(0);
    p = cyc;
    push(0, 1'b0, 5, p + 32);
    p0[1][1] = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    chk("press_valid", kv[0], 1);
    chk("press_key", k[0], 5);
    chk("press_down", kd[0], 1);
    repeat (16) @(posedge clk);
    #1;
    chk("press_single_pulse", kv[0], 0);
    chk("press_still_down", kd[0], 1);
    p0[1][1] = 1'b0;
    push(0, 1'b1, 5, p + 80);
    repeat (31) @(posedge clk);
    #1;
    chk("release_early_up", ku[0], 0);
    chk("release_early_down", kd[0], 1);
    @(posedge clk);
    #1;
    chk("release_up", ku[0], 1);
    chk("release_down", kd[0], 0);
    chk("release_key_kept", k[0], 5);
    @(posedge clk);
    #1;
    chk("release_up_pulse", ku[0], 0);

    // One-frame bounce on code 15 (r3,c0): must not be accepted.
    align(0);
    p0[3][0] = 1'b1;
    repeat (16) @(posedge clk);
    #1 p0[3][0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("bounce_down", kd[0], 0);
    chk("bounce_key_kept", k[0], 5);

    // Codes 1 (r0,c0) and 9 (r2,c2) together for 5 frames: rejected.
    align(0);
    p0[0][0] = 1'b1;
    p0[2][2] = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("multi_down", kd[0], 0);
    p0[0][0] = 1'b0;
    p0[2][2] = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    chk("multi_key_kept", k[0], 5);

    // Typematic repeat: code 0 (r3,c1) held 12 frames, repeat every 3 frames.
    align(1);
    p = cyc;
    p1[3][1] = 1'b1;
    push(1, 1'b0, 0, p + 32);
    push(1, 1'b0, 0, p + 80);
    push(1, 1'b0, 0, p + 128);
    push(1, 1'b0, 0, p + 176);
    repeat (192) @(posedge clk);
    #1;
    chk("repeat_held_down", kd[1], 1);
    p1[3][1] = 1'b0;
    push(1, 1'b1, 0, p + 224);
    repeat (40) @(posedge clk);
    #1;
    chk("repeat_released", kd[1], 0);

    // Raw mode 3x5: r2,c4 -> 14.
    align(2);
    p = cyc;
    p2[2][4] = 1'b1;
    push(2, 1'b0, 14, p + 24);
    repeat (36) @(posedge clk);
    #1;
    chk("raw_down", kd[2], 1);
    chk("raw_key", k[2], 14);
    p2[2][4] = 1'b0;
    push(2, 1'b1, 14, p + 60);
    repeat (30) @(posedge clk);
    #1;
    chk("raw_released", kd[2], 0);

    // Reset during debounce of code 2 (r0,c1): no acceptance, no key_up.
    align(0);
    p0[0][1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    p0[0][1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_key_cleared", k[0], 0);
    chk("rst_row", row0, 4'b1000);
    repeat (64) @(posedge clk);
    #1;
    chk("rst_no_accept", kd[0], 0);
    chk("rst_no_valid_key", k[0], 0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
